shift_exec_stage: RTL and testbench

//  Two-stage pipelined execute stage for the 16-bit CPU shift path. It accepts

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_core16.sv | 57 +++++
 rtl/shift_exec_stage.sv | 92 +++++++++
 tb/tb_shift_exec_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared encodings, widths and stage-1 payload for the shift path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef struct packed {
    shift_op_e         op;
    logic [AW-1:0]     amt;
    logic [DW-1:0]     data;
  } s1_payload_t;

endpackage

`default_nettype wire

// File: rtl/shift_core16.sv
// ============================================================================
// Module      : shift_core16
// Description : Combinational 1/2/4/8 log-shifter returning result and carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_core16
  import shift_pkg::*;
(
  input  shift_op_e        op,
  input  logic [AW-1:0]    amt,
  input  logic [DW-1:0]    data,
  output logic [DW-1:0]    result,
  output logic             c
);

  logic [DW-1:0] w_cur;
  logic          w_cry;

  // Each active layer overwrites the carry, so the last active layer holds the
  // final bit shifted out for the total amount.
  always_comb begin
    w_cur = data;
    w_cry = 1'b0;
    for (int i = 0; i < AW; i++) begin
      if (amt[i]) begin
        unique case (op)
          SH_LSL: begin
            w_cry = w_cur[AW'(DW - (1 << i))];
            w_cur = w_cur << (1 << i);
          end
          SH_LSR: begin
            w_cry = w_cur[AW'((1 << i) - 1)];
            w_cur = w_cur >> (1 << i);
          end
          SH_ASR: begin
            w_cry = w_cur[AW'((1 << i) - 1)];
            w_cur = DW'($signed(w_cur) >>> (1 << i));
          end
          SH_ROR: begin
            w_cur = (w_cur >> (1 << i)) | (w_cur << (DW - (1 << i)));
          end
          default: begin
            w_cur = w_cur;
          end
        endcase
      end
    end
  end

  assign result = w_cur;
  assign c      = (op == SH_ROR) ? ((amt != '0) & w_cur[DW-1]) : w_cry;

endmodule

`default_nettype wire

// File: rtl/shift_exec_stage.sv
// ============================================================================
// Module      : shift_exec_stage
// Description : Two-stage valid/ready execute stage for LSL/LSR/ASR/ROR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_exec_stage
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AW-1:0]    in_amt,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n
);

  s1_payload_t   r_s1;
  logic          r_s1_valid;
  logic          r_s2_valid;
  logic [DW-1:0] r_s2_data;
  logic          r_s2_c;
  logic          r_s2_z;
  logic          r_s2_n;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic [DW-1:0] w_core_res;
  logic          w_core_c;

  // out_ready reaches in_ready combinationally so a full pipe streams without bubbles.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  shift_core16 u_core (
    .op     (r_s1.op),
    .amt    (r_s1.amt),
    .data   (r_s1.data),
    .result (w_core_res),
    .c      (w_core_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_c     <= 1'b0;
      r_s2_z     <= 1'b0;
      r_s2_n     <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_core_res;
          r_s2_c    <= w_core_c;
          r_s2_z    <= (w_core_res == '0);
          r_s2_n    <= w_core_res[DW-1];
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1 <= '{op: shift_op_e'(in_op), amt: in_amt, data: in_data};
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_c     = r_s2_c;
  assign out_z     = r_s2_z;
  assign out_n     = r_s2_n;

endmodule

`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
// ============================================================================
// Module      : tb_shift_exec_stage
// Description : Directed self-checking bench for the shift execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_amt;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_c;
  logic        out_z;
  logic        out_n;

  int checks   = 0;
  int failures = 0;

  shift_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_c     (out_c),
    .out_z     (out_z),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated op: accept, wait the two-cycle latency, check, drain.
  task automatic run1(input string tag, input logic [1:0] op, input logic [3:0] amt,
                      input logic [15:0] data, input logic [15:0] exp, input logic expc);
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = data;
    step();
    in_valid = 1'b0;
    step();
    chk1 ({tag, "_valid"}, out_valid, 1'b1);
    chk16({tag, "_data"},  out_data,  exp);
    chk1 ({tag, "_c"},     out_c,     expc);
    chk1 ({tag, "_z"},     out_z,     exp == 16'h0000);
    chk1 ({tag, "_n"},     out_n,     exp[15]);
    step();
  endtask

  logic [1:0]  sop  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [3:0]  samt [8] = '{4'd4, 4'd1, 4'd4, 4'd8, 4'd8, 4'd8, 4'd2, 4'd1};
  logic [15:0] sdat [8] = '{16'h00F1, 16'h0003, 16'hF00F, 16'h12AB,
                            16'h01FF, 16'h8000, 16'h4001, 16'h0001};
  logic [15:0] sexp [8] = '{16'h0F10, 16'h0001, 16'hFF00, 16'hAB12,
                            16'hFF00, 16'h0080, 16'h1000, 16'h8000};
  logic        sc   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int          idx;
    int          got;
    int          cyc;
    logic        acc;
    logic [15:0] held;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_amt    = 4'd0;
    in_data   = 16'h0;
    out_ready = 1'b1;
    held      = 16'h0;

    step();
    step();
    chk1 ("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_data",  out_data,  16'h0000);
    chk1 ("rst_out_z",     out_z,     1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    step();

    // Back-to-back ASR then LSR on the same operand
    in_valid = 1'b1; in_op = 2'd2; in_amt = 4'd3; in_data = 16'h8010;
    step();
    in_op = 2'd1;
    step();
    in_valid = 1'b0;
    chk1 ("t1_asr_valid", out_valid, 1'b1);
    chk16("t1_asr_data",  out_data,  16'hF002);
    chk1 ("t1_asr_c",     out_c,     1'b0);
    chk1 ("t1_asr_n",     out_n,     1'b1);
    step();
    chk1 ("t1_lsr_valid", out_valid, 1'b1);
    chk16("t1_lsr_data",  out_data,  16'h1002);
    chk1 ("t1_lsr_c",     out_c,     1'b0);
    chk1 ("t1_lsr_n",     out_n,     1'b0);
    step();
    chk1("t1_drained", out_valid, 1'b0);

    run1("lsl1",   2'd0, 4'd1,  16'h8001, 16'h0002, 1'b1);
    run1("ror4",   2'd3, 4'd4,  16'h1234, 16'h4123, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run1("amt0", 2'(k), 4'd0, 16'h0000, 16'h0000, 1'b0);
    end
    run1("asr15",  2'd2, 4'd15, 16'h8000, 16'hFFFF, 1'b0);
    run1("lsr15",  2'd1, 4'd15, 16'hC000, 16'h0001, 1'b1);
    run1("lsl15",  2'd0, 4'd15, 16'h0003, 16'h8000, 1'b1);
    run1("asr0",   2'd2, 4'd0,  16'h8001, 16'h8001, 1'b0);
    run1("ror0",   2'd3, 4'd0,  16'h8001, 16'h8001, 1'b0);

    // Stream of 8 with out_ready low for cycles 3..6
    idx = 0;
    got = 0;
    cyc = 0;
    while ((idx < 8 || got < 8) && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        in_op   = sop[idx];
        in_amt  = samt[idx];
        in_data = sdat[idx];
      end
      #1;
      if (cyc == 3 || cyc == 6) chk1("stall_in_ready", in_ready, 1'b0);
      if (cyc == 3) begin
        chk1("stall_out_valid", out_valid, 1'b1);
        held = out_data;
      end
      if (cyc >= 4 && cyc <= 6) chk16("stall_hold", out_data, held);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (got < 8) begin
          chk16("stream_data", out_data, sexp[got]);
          chk1 ("stream_c",    out_c,    sc[got]);
        end
        got++;
      end
      if (acc) idx++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chki("stream_count", got, 8);
    chki("stream_accepted", idx, 8);
    step();
    chk1("stream_drained", out_valid, 1'b0);

    // Flush with both stages full and a new op offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_amt = 4'd1; in_data = 16'h0001;
    step();
    in_data = 16'h0002;
    step();
    chk1("fl_full_valid", out_valid, 1'b1);
    chk1("fl_full_ready", in_ready,  1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    in_data = 16'h0004;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk1("fl_out_valid", out_valid, 1'b0);
    step();
    chk1("fl_not_accepted", out_valid, 1'b0);
    run1("fl_after", 2'd3, 4'd4, 16'h000F, 16'hF000, 1'b1);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; in_op = 2'd0; in_amt = 4'd0; in_data = 16'h8000;
    step();
    in_data = 16'h1234; in_amt = 4'd1;
    step();
    in_valid = 1'b0;
    chk16("ar_pre_data", out_data, 16'h8000);
    chk1 ("ar_pre_n",    out_n,    1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("ar_out_valid", out_valid, 1'b0);
    chk16("ar_out_data",  out_data,  16'h0000);
    chk1 ("ar_out_c",     out_c,     1'b0);
    chk1 ("ar_out_z",     out_z,     1'b0);
    chk1 ("ar_out_n",     out_n,     1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    #1;
    chk1("ar_in_ready", in_ready, 1'b1);
    step();
    chk1("ar_no_output", out_valid, 1'b0);
    step();
    chk1("ar_no_output2", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
